// File: rtl/ddr_frame_write_ctrl.sv
// ddr_frame_write_ctrl: sequences fixed-length DDR write bursts through one frame of a selected bank
module ddr_frame_write_ctrl #(
   parameter int OFF_W     = 22,
   parameter int ADDR_W    = 24,
   parameter int BURST_LEN = 64,
   parameter int LEN_W     = 10,
   parameter int FRAME_LEN = 307200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_load,
   input  logic [1:0]        wr_bank,
   input  logic [LEN_W-1:0]  fifo_usedw,
   input  logic              wr_burst_finish,
   output logic              wr_burst_req,
   output logic [LEN_W-1:0]  wr_burst_len,
   output logic [ADDR_W-1:0] wr_burst_addr,
   output logic              frame_write_done,
   output logic              write_active
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_BURST = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   logic [1:0]        state_q, state_d;
   logic [OFF_W-1:0]  offset_q, offset_d;
   logic [1:0]        bank_q, bank_d, pend_bank_q, pend_bank_d;
   logic              pend_q, pend_d, req_q, req_d, done_q, done_d, active_q, active_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [OFF_W:0]    remain, next_off;
   logic [LEN_W-1:0]  need;
   assign remain   = (OFF_W+1)'(FRAME_LEN) - {1'b0, offset_q};
   assign need     = (remain < (OFF_W+1)'(BURST_LEN)) ? remain[LEN_W-1:0] : LEN_W'(BURST_LEN);
   assign next_off = {1'b0, offset_q} + (OFF_W+1)'(len_q);
   assign wr_burst_req     = req_q;
   assign wr_burst_len     = len_q;
   assign wr_burst_addr    = addr_q;
   assign frame_write_done = done_q;
   assign write_active     = active_q;
   // next-state: frame start/restart, burst issue on FIFO level, offset advance and pending restart
   always_comb begin
      state_d     = state_q;
      offset_d    = offset_q;
      bank_d      = bank_q;
      pend_d      = pend_q;
      pend_bank_d = pend_bank_q;
      req_d       = req_q;
      len_d       = len_q;
      addr_d      = addr_q;
      done_d      = done_q;
      active_d    = active_q;
      case (state_q)
         S_WAIT: begin
            if (wr_load) begin
               bank_d   = wr_bank;
               offset_d = '0;
            end else if (fifo_usedw >= need) begin
               state_d = S_BURST;
               req_d   = 1'b1;
               len_d   = need;
               addr_d  = {bank_q, offset_q};
            end
         end
         S_BURST: begin
            if (wr_burst_finish) begin
               req_d  = 1'b0;
               pend_d = 1'b0;
               if (pend_q || wr_load) begin
                  state_d  = S_WAIT;
                  bank_d   = wr_load ? wr_bank : pend_bank_q;
                  offset_d = '0;
               end else if (next_off == (OFF_W+1)'(FRAME_LEN)) begin
                  state_d  = S_DONE;
                  offset_d = next_off[OFF_W-1:0];
                  done_d   = 1'b1;
                  active_d = 1'b0;
               end else begin
                  state_d  = S_WAIT;
                  offset_d = next_off[OFF_W-1:0];
               end
            end else if (wr_load) begin
               pend_d      = 1'b1;
               pend_bank_d = wr_bank;
            end
         end
         default: begin
            if (wr_load) begin
               state_d  = S_WAIT;
               bank_d   = wr_bank;
               offset_d = '0;
               done_d   = 1'b0;
               active_d = 1'b1;
            end
         end
      endcase
   end
   // state registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         offset_q    <= '0;
         bank_q      <= '0;
         pend_q      <= 1'b0;
         pend_bank_q <= '0;
         req_q       <= 1'b0;
         len_q       <= '0;
         addr_q      <= '0;
         done_q      <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         offset_q    <= offset_d;
         bank_q      <= bank_d;
         pend_q      <= pend_d;
         pend_bank_q <= pend_bank_d;
         req_q       <= req_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         done_q      <= done_d;
         active_q    <= active_d;
      end
   end
endmodule

// File: doc/ddr_frame_write_ctrl.md
Name: ddr_frame_write_ctrl

Overview:
- Write-side DMA sequencer between the CMOS pixel write FIFO and the DDR burst controller.
- Consumes `wr_load` / `wr_bank` from the ping-pong bank switcher.
- Issues fixed-length DDR write bursts into the selected bank, advancing through one frame's worth of words.
- Reports `frame_write_done` back to the bank switcher so it can swap write banks.

Parameters:
- OFF_W, 22, width of the word offset inside one bank.
- ADDR_W, 24, DDR burst address width; equals 2 + OFF_W, with bank in the MSBs.
- BURST_LEN, 64, words per full burst; must be ≤ 2^LEN_W − 1.
- LEN_W, 10, width of the burst length and FIFO level buses.
- FRAME_LEN, 307200, words per frame (640x480 at one pixel per word); must be ≥ 1.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- wr_load, input, 1, one-cycle pulse that starts a new frame in bank `wr_bank`.
- wr_bank, input, 2, target bank; sampled only when `wr_load` = 1.
- fifo_usedw, input, LEN_W, current fill level of the pixel write FIFO, in words.
- wr_burst_finish, input, 1, one-cycle pulse from the DDR controller when the current burst completes.
- wr_burst_req, output, 1, burst request; level signal.
- wr_burst_len, output, LEN_W, word count of the current burst.
- wr_burst_addr, output, ADDR_W, word start address of the current burst.
- frame_write_done, output, 1, level signal: the full frame has been written to the latched bank.
- write_active, output, 1, high from frame start until `frame_write_done`.

Behaviour:
- Reset (asynchronous, `rst` = 1): state = IDLE, offset = 0, bank_q = 0, and all outputs = 0.
- States: IDLE, WAIT_DATA, BURST, DONE.
- IDLE:
  - Outputs are low.
  - On `wr_load` go to WAIT_DATA: bank_q <= `wr_bank`, offset <= 0, `write_active` <= 1.
- WAIT_DATA:
  - remain = FRAME_LEN − offset; need = min(BURST_LEN, remain).
  - When `fifo_usedw` ≥ need, go to BURST. Registered on the same edge: `wr_burst_req` <= 1, `wr_burst_len` <= need, `wr_burst_addr` <= {bank_q, offset}.
  - Request latency is therefore 1 cycle after the FIFO condition is met.
- BURST:
  - `wr_burst_req`, `wr_burst_len` and `wr_burst_addr` are held stable until `wr_burst_finish`.
  - On `wr_burst_finish`: `wr_burst_req` <= 0 and offset <= offset + `wr_burst_len`.
  - If the new offset = FRAME_LEN, go to DONE: `frame_write_done` <= 1, `write_active` <= 0. Otherwise go to WAIT_DATA.
  - Minimum gap between bursts: 1 cycle with `wr_burst_req` low.
- DONE:
  - `frame_write_done` stays at 1 until the next `wr_load`.
  - On `wr_load`: `frame_write_done` <= 0, latch the new bank, offset <= 0, go to WAIT_DATA.
- Last burst of a frame is partial when FRAME_LEN is not a multiple of BURST_LEN; its length is FRAME_LEN mod BURST_LEN.
- `wr_load` in WAIT_DATA restarts the frame immediately: new bank, offset 0.
- `wr_load` in BURST is recorded in a pending flag.
  - The burst completes normally and offset is updated.
  - The pending restart is then applied instead of the normal next-state: WAIT_DATA, new bank, offset 0, `frame_write_done` stays 0.
  - The bank is taken from `wr_bank` at pending capture time; a second `wr_load` before finish overwrites it.
- `wr_load` coincident with `wr_burst_finish` is treated as pending-then-applied on the same edge: the restart wins.
- `wr_burst_finish` outside BURST is ignored.
- No address carry into the bank bits: offset never exceeds FRAME_LEN ≤ 2^OFF_W.

Test Plan:
- Basic frame:
  - FRAME_LEN = 200, BURST_LEN = 64, `fifo_usedw` = 100 constant, `wr_bank` = 2'b01, finish 10 cycles after each req.
  - Required: 4 bursts, lengths 64, 64, 64, 8, addresses 0x400000, 0x400040, 0x400080, 0x4000C0.
  - `frame_write_done` rises 1 cycle after the 4th finish and holds.
- FIFO starvation:
  - `fifo_usedw` = 63 for 50 cycles, then 64.
  - Required: `wr_burst_req` stays 0 during starvation and asserts exactly 1 cycle after `fifo_usedw` reaches 64.
- Partial tail threshold: at offset 192, `fifo_usedw` = 8 → request issued with `wr_burst_len` = 8 (the request is not held back waiting for 64 words).
- Restart mid-burst:
  - `wr_load` with `wr_bank` = 2'b10 during the 2nd burst.
  - Required: the burst completes, the next request address is 0x800000 with len 64, and `frame_write_done` never asserts for the aborted frame.
- Ping-pong handoff: in DONE, pulse `wr_load` with `wr_bank` = 2'b00 → `frame_write_done` falls the next cycle and the first request address is 0x000000.
- Async reset: assert `rst` while `wr_burst_req` = 1 → `wr_burst_req`, `frame_write_done` and `write_active` are 0 with no clock edge; after release the block stays idle until `wr_load`.
